// File: rtl/uart_host_tx.sv
// uart_host_tx: byte FIFO feeding an LSB-first 8N1/8N2 serialiser; define UART_TX_PARITY_EN to add a parity bit.
// Latency: a byte pushed into an empty FIFO while idle drives the start bit from the next edge.
// Backpressure: wr_ready drops while FIFO_DEPTH bytes are queued; queued frames go out with no idle gap.
module uart_host_tx #(
  parameter int CLKS_PER_BIT = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_host_tx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t             state, state_n;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]      count_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         bit_idx, bit_n;
  logic [7:0]         data_q, data_n;
  logic               tx_n, done_n, push, pop, cnt_last, fifo_nonempty;

  assign push          = wr_valid & wr_ready;
  assign cnt_last      = (cnt == CNT_LAST);
  assign fifo_nonempty = (fifo_count != '0);
  assign count_n       = fifo_count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    data_n  = data_q;
    tx_n    = tx;
    done_n  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          data_n  = mem[rd_ptr];
          tx_n    = 1'b0;
          cnt_n   = '0;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = data_q[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            tx_n    = (PARITY_ODD != 0) ? ~^data_q : ^data_q;
            state_n = PARITY;
`else
            tx_n    = 1'b1;
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = data_q[bit_n];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        // Pulse lands on the final cycle of the last stop bit, hence one count early.
        done_n = (bit_idx == STOP_LAST) && (cnt == CNT_DONE);
        if (cnt_last) begin
          cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_n = '0;
            if (fifo_nonempty) begin
              pop     = 1'b1;
              data_n  = mem[rd_ptr];
              tx_n    = 1'b0;
              state_n = START;
            end else begin
              tx_n    = 1'b1;
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      busy       <= 1'b0;
      wr_ready   <= 1'b1;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      data_q     <= data_n;
      tx         <= tx_n;
      tx_done    <= done_n;
      busy       <= (state_n != IDLE) || (count_n != '0);
      wr_ready   <= (count_n != CW'(FIFO_DEPTH));
      fifo_count <= count_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_host_tx.sv
// Bench for uart_host_tx: frame-level reference model compared every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_uart_host_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int SB    = 1;
  localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 10 + SB;
`else
  localparam int NBITS = 9 + SB;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_ready, tx, busy, tx_done;
  logic [3:0] fifo_count;

  int vec = 0;
  int err = 0;

  // Reference model: queue of waiting bytes plus the frame currently on the line.
  byte unsigned mq[$];
  bit           m_act = 1'b0;
  byte unsigned m_cur = 8'h00;
  int           m_t   = 0;
  int           m_acc = 0;

  uart_host_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .STOP_BITS   (SB),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line level for bit slot k of the frame carrying byte d.
  function automatic int frame_bit(input byte unsigned d, input int k);
    if (k == 0) return 0;
    if (k <= 8) return int'(d[k-1]);
`ifdef UART_TX_PARITY_EN
    if (k == 9) return (PODD != 0) ? int'(~^d) : int'(^d);
`endif
    return 1;
  endfunction

  always @(posedge clk) begin : model
    int qb;
    bit acc;
    if (!reset_n) begin
      mq.delete();
      m_act = 1'b0;
      m_t   = 0;
    end else begin
      qb  = mq.size();
      acc = wr_valid && (qb < DEPTH);
      if (m_act) begin
        m_t++;
        if (m_t == FL) begin
          if (qb != 0) begin
            m_cur = mq.pop_front();
            m_t   = 0;
          end else begin
            m_act = 1'b0;
          end
        end
      end else if (qb != 0) begin
        m_cur = mq.pop_front();
        m_act = 1'b1;
        m_t   = 0;
      end
      if (acc) begin
        mq.push_back(wr_data);
        m_acc++;
      end
    end
    #1;
    chk("tx",         tx,         m_act ? frame_bit(m_cur, m_t / CPB) : 1);
    chk("tx_done",    tx_done,    (m_act && m_t == FL - 1) ? 1 : 0);
    chk("busy",       busy,       (m_act || mq.size() != 0) ? 1 : 0);
    chk("fifo_count", fifo_count, mq.size());
    chk("wr_ready",   wr_ready,   (mq.size() < DEPTH) ? 1 : 0);
  end

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((m_act || mq.size() != 0) && n < bound) begin
      @(posedge clk); #2;
      n++;
    end
    @(posedge clk); #2;
    vec++;
    if (m_act || mq.size() != 0) begin
      err++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic send_one(input logic [7:0] d, output logic [15:0] bits,
                          output int done_at, output int fall_at);
    wait_idle(12 * FL);
    @(negedge clk); wr_valid = 1'b1; wr_data = d;
    @(posedge clk);
    @(negedge clk); wr_valid = 1'b0; wr_data = 8'($urandom);
    bits = '0; done_at = -1; fall_at = -1;
    for (int i = 1; i <= FL + 20; i++) begin
      @(posedge clk); #2;
      if ((i - 1) % CPB == CPB / 2 && (i - 1) / CPB < 16) bits[(i - 1) / CPB] = tx;
      if (tx_done && done_at < 0) done_at = i;
      if (!busy && fall_at < 0) fall_at = i;
    end
  endtask

  initial begin
    logic [15:0] bits;
    int done_at, fall_at, acc0, dones, lows;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx", tx, 1);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_tx_done", tx_done, 0);
    chk("reset_fifo_count", fifo_count, 0);
    @(negedge clk); reset_n = 1'b1;

    // Single 0x55 frame: alternating bits, done on last stop cycle, busy falls one later.
    send_one(8'h55, bits, done_at, fall_at);
    for (int k = 0; k < 9; k++) chk("t1_bit", bits[k], k % 2);
    chk("t1_stop", bits[NBITS - 1], 1);
    chk("t1_done_cycle", done_at, FL);
    chk("t1_busy_fall", fall_at, FL + 1);

`ifdef UART_TX_PARITY_EN
    send_one(8'h07, bits, done_at, fall_at);
    chk("t5_parity_07", bits[9], 1);
    chk("t5_frame_len", done_at, 176);
    send_one(8'h03, bits, done_at, fall_at);
    chk("t5_parity_03", bits[9], 0);
`endif

    // Three back-to-back bytes: one continuous burst of 3 frames.
    wait_idle(12 * FL);
    @(negedge clk); wr_valid = 1'b1; wr_data = 8'h48;
    @(posedge clk);
    @(negedge clk); wr_data = 8'h69;
    @(negedge clk); wr_data = 8'h0A;
    @(negedge clk); wr_valid = 1'b0;
    dones = 0; fall_at = -1;
    for (int i = 3; i <= 3 * FL + 20; i++) begin
      @(posedge clk); #2;
      if (tx_done) dones++;
      if (!busy && fall_at < 0) fall_at = i;
    end
    chk("t2_done_pulses", dones, 3);
    chk("t2_busy_fall", fall_at, 3 * FL + 1);

    // Ten consecutive pushes: nine fit, ready drops after the ninth.
    wait_idle(12 * FL);
    acc0 = m_acc;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); wr_valid = 1'b1; wr_data = 8'($urandom);
      @(posedge clk); #2;
      chk("t3_wr_ready", wr_ready, (k < 9) ? 1 : 0);
    end
    @(negedge clk); wr_valid = 1'b0;
    chk("t3_accepted", m_acc - acc0, 9);
    wait_idle(12 * FL);

    // Async reset in the middle of a data bit with one byte still queued.
    @(negedge clk); wr_valid = 1'b1; wr_data = 8'hA3;
    @(negedge clk); wr_data = 8'h11;
    @(negedge clk); wr_valid = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    chk("t4_pre_count", fifo_count, 1);
    #1; reset_n = 1'b0;
    #1;
    chk("t4_rst_tx", tx, 1);
    chk("t4_rst_count", fifo_count, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ready", wr_ready, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dones = 0; lows = 0;
    for (int i = 0; i < FL + 40; i++) begin
      @(posedge clk); #2;
      if (tx_done) dones++;
      if (!tx) lows++;
      if (busy) lows++;
    end
    chk("t4_no_done", dones, 0);
    chk("t4_no_resume", lows, 0);

    // Random traffic, alternating heavy and light phases.
    for (int blk = 0; blk < 10; blk++) begin
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        wr_valid = (blk % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
        wr_data  = 8'($urandom);
      end
    end
    @(negedge clk); wr_valid = 1'b0;
    wait_idle(12 * FL);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
